// File: rtl/multi_cycle_datapath.sv
// rtl/multi_cycle_datapath.sv - multi-cycle MIPS-subset core on one shared ready-handshaked memory port
module multi_cycle_datapath #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] Mem_RData,
   input  logic              Mem_Ready,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_WData,
   output logic              Mem_Read,
   output logic              Mem_Write,
   output logic              Instr_Done,
   output logic              Halted
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       ir;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] mdr;
   logic [DATA_W-1:0] regs [32];

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign imm   = ir[15:0];
   assign funct = ir[5:0];

   logic is_rtype;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_addi;
   logic is_j;
   logic is_legal;

   always_comb begin
      is_rtype = 1'b0;
      if (op == OP_RTYPE) begin
         case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: is_rtype = 1'b1;
            default:                          is_rtype = 1'b0;
         endcase
      end
   end

   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_beq   = (op == OP_BEQ);
   assign is_addi  = (op == OP_ADDI);
   assign is_j     = (op == OP_J);
   assign is_legal = is_rtype | is_lw | is_sw | is_beq | is_addi | is_j;

   logic [DATA_W-1:0] ext_imm;
   logic [DATA_W-1:0] ext_sh;
   assign ext_imm = {{(DATA_W-16){imm[15]}}, imm};
   assign ext_sh  = ext_imm << 2;

   // Address-width adaptation between the DATA_W datapath and the ADDR_W PC/port
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] alu_addr;
   logic [ADDR_W-1:0] jump_target;

   generate
      if (ADDR_W <= DATA_W) begin : g_addr_narrow
         assign br_off   = ext_sh[ADDR_W-1:0];
         assign alu_addr = alu_out[ADDR_W-1:0];
      end else begin : g_addr_wide
         assign br_off   = {{(ADDR_W-DATA_W){ext_sh[DATA_W-1]}}, ext_sh};
         assign alu_addr = {{(ADDR_W-DATA_W){1'b0}}, alu_out};
      end

      if (ADDR_W > 28) begin : g_jump_region
         assign jump_target = {pc[ADDR_W-1:28], ir[25:0], 2'b00};
      end else begin : g_jump_flat
         logic [27:0] unused_jt;
         assign unused_jt   = {ir[25:0], 2'b00};
         assign jump_target = unused_jt[ADDR_W-1:0];
      end
   endgenerate

   logic unused_bits;
   assign unused_bits = ^{ir[10:6], ext_sh, alu_out};

   logic [DATA_W-1:0] alu_result;
   logic              slt_bit;

   assign slt_bit = ($signed(a_reg) < $signed(b_reg));

   always_comb begin
      alu_result = a_reg + ext_imm;
      if (is_rtype) begin
         case (funct)
            F_ADD:   alu_result = a_reg + b_reg;
            F_SUB:   alu_result = a_reg - b_reg;
            F_AND:   alu_result = a_reg & b_reg;
            F_OR:    alu_result = a_reg | b_reg;
            F_SLT:   alu_result = {{(DATA_W-1){1'b0}}, slt_bit};
            default: alu_result = a_reg + b_reg;
         endcase
      end
   end

   logic [4:0]        wb_dst;
   logic [DATA_W-1:0] wb_data;
   assign wb_dst  = is_rtype ? rd : rt;
   assign wb_data = is_lw ? mdr : alu_out;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= S_FETCH;
         pc      <= PC_RESET;
         ir      <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         alu_out <= '0;
         mdr     <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (Mem_Ready) begin
                  ir    <= Mem_RData[31:0];
                  pc    <= pc + ADDR_W'(4);
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_reg <= regs[rs];
               b_reg <= regs[rt];
               if (!is_legal) begin
                  state <= S_HALT;
               end else if (is_j) begin
                  pc    <= jump_target;
                  state <= S_FETCH;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               alu_out <= alu_result;
               if (is_beq) begin
                  if (a_reg == b_reg) pc <= pc + br_off;
                  state <= S_FETCH;
               end else if (is_lw || is_sw) begin
                  state <= S_MEM;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (Mem_Ready) begin
                  if (is_lw) begin
                     mdr   <= Mem_RData;
                     state <= S_WB;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               // $0 is hardwired: a write aimed at it is simply dropped
               if (wb_dst != 5'd0) regs[wb_dst] <= wb_data;
               state <= S_FETCH;
            end
            default: state <= S_HALT;
         endcase
      end
   end

   always_comb begin
      Mem_Addr   = '0;
      Mem_WData  = '0;
      Mem_Read   = 1'b0;
      Mem_Write  = 1'b0;
      Instr_Done = 1'b0;
      Halted     = 1'b0;
      if (!Reset) begin
         case (state)
            S_FETCH: begin
               Mem_Read = 1'b1;
               Mem_Addr = pc;
            end
            S_DECODE: Instr_Done = is_legal & is_j;
            S_EXEC:   Instr_Done = is_beq;
            S_MEM: begin
               Mem_Addr = alu_addr;
               if (is_lw) Mem_Read = 1'b1;
               if (is_sw) begin
                  Mem_Write  = 1'b1;
                  Mem_WData  = b_reg;
                  Instr_Done = Mem_Ready;
               end
            end
            S_WB:     Instr_Done = 1'b1;
            S_HALT:   Halted = 1'b1;
            default:  Halted = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_datapath.sv
// tb/tb_multi_cycle_datapath.sv - directed bench for multi_cycle_datapath
module tb_multi_cycle_datapath;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Mem_Ready = 1'b1;
   logic [31:0] Mem_RData;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_WData;
   logic        Mem_Read;
   logic        Mem_Write;
   logic        Instr_Done;
   logic        Halted;

   int          checks = 0;
   int          errors = 0;
   int          phase = 0;
   int          n;
   logic [31:0] data_word = '0;
   logic [31:0] wr_addr = '0;

   always #5 Clock = ~Clock;

   multi_cycle_datapath #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .PC_RESET(32'h0)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Mem_RData (Mem_RData),
      .Mem_Ready (Mem_Ready),
      .Mem_Addr  (Mem_Addr),
      .Mem_WData (Mem_WData),
      .Mem_Read  (Mem_Read),
      .Mem_Write (Mem_Write),
      .Instr_Done(Instr_Done),
      .Halted    (Halted)
   );

   function automatic logic [31:0] rom(input int ph, input logic [31:0] a);
      if (ph == 1) return (a == 32'h0) ? 32'hFC000000 : 32'h0;
      if (ph == 2) return (a == 32'h0) ? 32'h8C090010 : 32'h0;
      case (a)
         32'h00: return 32'h20010005;  // addi $1,$0,5
         32'h04: return 32'h2002FFFD;  // addi $2,$0,-3
         32'h08: return 32'h00221820;  // add  $3,$1,$2
         32'h0C: return 32'h08000010;  // j    0x40
         32'h40: return 32'hAC030010;  // sw   $3,16($0)
         32'h44: return 32'h8C040010;  // lw   $4,16($0)
         32'h48: return 32'h0041282A;  // slt  $5,$2,$1
         32'h4C: return 32'h00053022;  // sub  $6,$0,$5
         32'h50: return 32'h00210020;  // add  $0,$1,$1
         32'h54: return 32'h00223824;  // and  $7,$1,$2
         32'h58: return 32'h00224025;  // or   $8,$1,$2
         32'h5C: return 32'h10220005;  // beq  $1,$2,+5
         32'h60: return 32'h1021FFFF;  // beq  $1,$1,-1
         default: return 32'h0;
      endcase
   endfunction

   assign Mem_RData = (Mem_Addr == 32'd16) ? data_word : rom(phase, Mem_Addr);

   always @(posedge Clock) begin
      if (Mem_Write && Mem_Ready && !Reset) begin
         data_word <= Mem_WData;
         wr_addr   <= Mem_Addr;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic rdy);
      @(posedge Clock);
      #1;
      Reset     = rst;
      Mem_Ready = rdy;
      #2;
   endtask

   task automatic run_instr(output int cnt);
      cnt = 0;
      do begin
         cyc(1'b0, 1'b1);
         cnt++;
      end while (!Instr_Done && cnt < 20);
   endtask

   initial begin
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      check("rst_read", Mem_Read, 0);
      check("rst_write", Mem_Write, 0);
      check("rst_addr", Mem_Addr, 0);
      check("rst_done", Instr_Done, 0);
      check("rst_halted", Halted, 0);

      for (int c = 1; c <= 12; c++) begin
         cyc(1'b0, 1'b1);
         if (c == 1) begin
            check("first_read", Mem_Read, 1);
            check("first_addr", Mem_Addr, 0);
         end
         check("done_cycle", Instr_Done, (c % 4 == 0) ? 1 : 0);
      end
      check("addi_r1", dut.regs[1], 32'd5);
      check("addi_r2", dut.regs[2], 32'hFFFFFFFD);

      cyc(1'b0, 1'b1);
      check("j_fetch_addr", Mem_Addr, 32'h0C);
      check("add_r3", dut.regs[3], 32'd2);
      cyc(1'b0, 1'b1);
      check("j_done", Instr_Done, 1);
      cyc(1'b0, 1'b1);
      check("j_target", Mem_Addr, 32'h40);

      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, (k == 2));
         check("sw_write", Mem_Write, 1);
         check("sw_addr", Mem_Addr, 32'd16);
         check("sw_wdata", Mem_WData, 32'd2);
         check("sw_done", Instr_Done, (k == 2) ? 1 : 0);
      end

      cyc(1'b0, 1'b1);
      check("lw_fetch_addr", Mem_Addr, 32'h44);
      check("sw_mem_data", data_word, 32'd2);
      check("sw_mem_addr", wr_addr, 32'd16);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, (k == 2));
         check("lw_read", Mem_Read, 1);
         check("lw_addr", Mem_Addr, 32'd16);
         check("lw_done_early", Instr_Done, 0);
      end
      cyc(1'b0, 1'b1);
      check("lw_done", Instr_Done, 1);

      run_instr(n);
      check("slt_cycles", n, 4);
      check("lw_r4", dut.regs[4], 32'd2);
      run_instr(n);
      check("sub_cycles", n, 4);
      check("slt_r5", dut.regs[5], 32'd1);
      run_instr(n);
      check("add0_cycles", n, 4);
      check("sub_r6", dut.regs[6], 32'hFFFFFFFF);
      run_instr(n);
      check("and_cycles", n, 4);
      check("add_r0", dut.regs[0], 32'd0);
      run_instr(n);
      check("or_cycles", n, 4);
      check("and_r7", dut.regs[7], 32'd5);
      run_instr(n);
      check("beq_ne_cycles", n, 3);
      check("or_r8", dut.regs[8], 32'hFFFFFFFD);

      cyc(1'b0, 1'b1);
      check("beq_ne_fall_addr", Mem_Addr, 32'h60);
      check("beq_ne_fall_read", Mem_Read, 1);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1);
         cyc(1'b0, 1'b1);
         check("beq_loop_done", Instr_Done, 1);
         cyc(1'b0, 1'b1);
         check("beq_loop_addr", Mem_Addr, 32'h60);
      end

      phase = 1;
      cyc(1'b1, 1'b1);
      check("rst2_read", Mem_Read, 0);
      cyc(1'b0, 1'b1);
      check("ill_fetch_addr", Mem_Addr, 0);
      check("ill_fetch_read", Mem_Read, 1);
      cyc(1'b0, 1'b1);
      check("ill_decode_halted", Halted, 0);
      check("ill_decode_done", Instr_Done, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1);
         check("halt_flag", Halted, 1);
         check("halt_read", Mem_Read, 0);
         check("halt_write", Mem_Write, 0);
      end
      check("halt_pc", dut.pc, 32'd4);

      phase = 2;
      cyc(1'b1, 1'b1);
      check("rst3_halted", Halted, 0);
      cyc(1'b0, 1'b0);
      check("resume_read", Mem_Read, 1);
      check("resume_addr", Mem_Addr, 0);
      cyc(1'b0, 1'b1);
      check("fetch_wait_addr", Mem_Addr, 0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      check("held_lw_read", Mem_Read, 1);
      check("held_lw_addr", Mem_Addr, 32'd16);
      cyc(1'b1, 1'b0);
      check("rst_mid_read", Mem_Read, 0);
      check("rst_mid_addr", Mem_Addr, 0);
      cyc(1'b0, 1'b0);
      check("after_rst_read", Mem_Read, 1);
      check("after_rst_addr", Mem_Addr, 0);
      check("after_rst_r9", dut.regs[9], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
